// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the control unit and the shift sequencer.
// The control unit drives the master side; the sequencer implements the slave side.
interface shift_sequencer_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);
   logic               start;
   logic [2:0]         op;
   logic [WIDTH-1:0]   a;
   logic [SHAMT_W-1:0] shamt;
   logic               busy;
   logic               done;
   logic               err;
   logic [WIDTH-1:0]   result;

   modport master (
      output start, op, a, shamt,
      input  busy, done, err, result
   );

   modport slave (
      input  start, op, a, shamt,
      output busy, done, err, result
   );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate unit: shifts the captured operand by up to STEP bits per
// cycle until the requested amount is consumed, then pulses done for one cycle.
module shift_sequencer #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 1
) (
   input  logic              Clock,
   input  logic              Clear,
   shift_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      OP_SHR  = 3'b000,
      OP_SHRA = 3'b001,
      OP_SHL  = 3'b010,
      OP_ROR  = 3'b011,
      OP_ROL  = 3'b100
   } op_e;

   localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);
   localparam logic [SHAMT_W:0]   WIDTH_AMT = (SHAMT_W+1)'(WIDTH);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   logic [2:0]         op_q, op_d;
   logic               illegal_q, illegal_d;

   logic [SHAMT_W-1:0] k;
   logic [SHAMT_W:0]   k_inv;
   logic [WIDTH-1:0]   shifted;
   logic               start_illegal;

   // Amount consumed this cycle; the last step may be shorter than STEP.
   always_comb begin
      k     = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
      k_inv = WIDTH_AMT - {1'b0, k};
   end

   // NOTE: every variable assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      shifted = result_q;
      case (op_q)
         OP_SHR:  shifted = result_q >> k;
         OP_SHRA: shifted = $unsigned($signed(result_q) >>> k);
         OP_SHL:  shifted = result_q << k;
         OP_ROR:  shifted = (result_q >> k) | (result_q << k_inv);
         OP_ROL:  shifted = (result_q << k) | (result_q >> k_inv);
         default: shifted = result_q;
      endcase
   end

   assign start_illegal = (bus.op > OP_ROL);

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      rem_d     = rem_q;
      op_d      = op_q;
      illegal_d = illegal_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               result_d  = bus.a;
               op_d      = bus.op;
               rem_d     = bus.shamt;
               illegal_d = start_illegal;
               state_d   = (start_illegal || bus.shamt == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            result_d = shifted;
            rem_d    = rem_q - k;
            if (rem_q == k) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples its _d value from before the edge.
   always_ff @(posedge Clock) begin
      if (Clear) begin
         state_q   <= S_IDLE;
         result_q  <= '0;
         rem_q     <= '0;
         op_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         rem_q     <= rem_d;
         op_q      <= op_d;
         illegal_q <= illegal_d;
      end
   end

   // Outputs are decodes of registered state only; nothing reaches them from the inputs.
   assign bus.busy   = (state_q != S_IDLE);
   assign bus.done   = (state_q == S_DONE);
   assign bus.err    = (state_q == S_DONE) && illegal_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Drives one STEP=1 and one STEP=4 sequencer with identical requests and checks
// latency, busy span, result and err against an arithmetic reference model.
module tb_shift_sequencer;

   logic        Clock;
   logic        Clear;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [4:0]  shamt;

   int n_vec = 0;
   int n_err = 0;

   shift_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) u_if1 ();
   shift_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) u_if4 ();

   assign u_if1.start = start;
   assign u_if1.op    = op;
   assign u_if1.a     = a;
   assign u_if1.shamt = shamt;
   assign u_if4.start = start;
   assign u_if4.op    = op;
   assign u_if4.a     = a;
   assign u_if4.shamt = shamt;

   shift_sequencer #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_dut1 (
      .Clock (Clock),
      .Clear (Clear),
      .bus   (u_if1.slave)
   );

   shift_sequencer #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_dut4 (
      .Clock (Clock),
      .Clear (Clear),
      .bus   (u_if4.slave)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input int s);
      logic [63:0]        d;
      logic [63:0]        t;
      logic signed [31:0] sx;
      d  = {x, x};
      sx = x;
      case (o)
         3'd0: return x >> s;
         3'd1: return sx >>> s;
         3'd2: return x << s;
         3'd3: begin t = d >> s; return t[31:0]; end
         3'd4: begin t = d << s; return t[63:32]; end
         default: return x;
      endcase
   endfunction

   task automatic next_cycle();
      @(posedge Clock);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " res1"},  64'(u_if1.result), 64'd0);
      check({tag, " busy1"}, 64'(u_if1.busy),   64'd0);
      check({tag, " done1"}, 64'(u_if1.done),   64'd0);
      check({tag, " err1"},  64'(u_if1.err),    64'd0);
      check({tag, " res4"},  64'(u_if4.result), 64'd0);
      check({tag, " busy4"}, 64'(u_if4.busy),   64'd0);
      check({tag, " done4"}, 64'(u_if4.done),   64'd0);
      check({tag, " err4"},  64'(u_if4.err),    64'd0);
   endtask

   // One request; inject re-asserts start with different operands while both units are busy.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                         input logic [4:0] s, input bit inject);
      logic [31:0] exp;
      bit          ill;
      int          lat1, lat4;
      int          seen1, seen4, dcnt1, dcnt4, bcnt1, bcnt4;
      logic [31:0] res1, res4;
      logic        err1, err4;

      exp   = model(o, av, int'(s));
      ill   = (o > 3'd4);
      lat1  = ill ? 0 : int'(s);
      lat4  = ill ? 0 : (int'(s) + 3) / 4;
      seen1 = -1; seen4 = -1;
      dcnt1 = 0;  dcnt4 = 0;
      bcnt1 = 0;  bcnt4 = 0;
      res1  = '0; res4 = '0;
      err1  = 1'b0; err4 = 1'b0;

      start = 1'b1; op = o; a = av; shamt = s;
      next_cycle();
      start = 1'b0;
      for (int j = 0; j < 40; j++) begin
         if (inject && j == 1) begin
            start = 1'b1; a = ~av; op = 3'd2; shamt = 5'd1;
         end
         if (inject && j == 2) start = 1'b0;
         if (u_if1.done) begin
            dcnt1++;
            if (seen1 < 0) begin seen1 = j; res1 = u_if1.result; err1 = u_if1.err; end
         end
         if (u_if4.done) begin
            dcnt4++;
            if (seen4 < 0) begin seen4 = j; res4 = u_if4.result; err4 = u_if4.err; end
         end
         if (u_if1.busy) bcnt1++;
         if (u_if4.busy) bcnt4++;
         next_cycle();
      end

      check({tag, " lat1"},   64'(seen1), 64'(lat1));
      check({tag, " res1"},   64'(res1),  64'(exp));
      check({tag, " err1"},   64'(err1),  64'(ill));
      check({tag, " ndone1"}, 64'(dcnt1), 64'd1);
      check({tag, " busy1"},  64'(bcnt1), 64'(lat1 + 1));
      check({tag, " hold1"},  64'(u_if1.result), 64'(exp));
      check({tag, " lat4"},   64'(seen4), 64'(lat4));
      check({tag, " res4"},   64'(res4),  64'(exp));
      check({tag, " err4"},   64'(err4),  64'(ill));
      check({tag, " ndone4"}, 64'(dcnt4), 64'd1);
      check({tag, " busy4"},  64'(bcnt4), 64'(lat4 + 1));
      check({tag, " hold4"},  64'(u_if4.result), 64'(exp));
   endtask

   initial begin
      int dcnt;
      logic [31:0] ra;

      Clear = 1'b1; start = 1'b0; op = '0; a = '0; shamt = '0;
      next_cycle();
      next_cycle();
      check_zero("reset");
      Clear = 1'b0;
      next_cycle();

      run_op("shr5",   3'b000, 32'h8000_0012, 5'd5, 1'b0);
      run_op("shra5",  3'b001, 32'h8000_0012, 5'd5, 1'b0);
      run_op("shl4",   3'b010, 32'h8000_0012, 5'd4, 1'b0);
      run_op("ror4",   3'b011, 32'h8000_0012, 5'd4, 1'b0);
      run_op("rol4",   3'b100, 32'h8000_0012, 5'd4, 1'b0);
      run_op("shrff5", 3'b000, 32'hFFFF_FFFF, 5'd5, 1'b0);
      run_op("shamt0", 3'b000, 32'hDEAD_BEEF, 5'd0, 1'b0);
      run_op("illegal",3'b110, 32'h1234_5678, 5'd7, 1'b0);
      run_op("ignore", 3'b011, 32'hA5C3_0F96, 5'd13, 1'b1);
      run_op("max31",  3'b001, 32'h8000_0001, 5'd31, 1'b0);

      // Abort mid-shift: Clear lands on the third edge after the start edge.
      ra = $urandom;
      dcnt = 0;
      start = 1'b1; op = 3'b100; a = ra; shamt = 5'd20;
      next_cycle();
      start = 1'b0;
      for (int j = 0; j < 3; j++) begin
         if (u_if1.done || u_if4.done) dcnt++;
         if (j == 2) Clear = 1'b1;
         else next_cycle();
      end
      next_cycle();
      check_zero("midclr");
      Clear = 1'b0;
      for (int j = 0; j < 30; j++) begin
         if (u_if1.done || u_if4.done) dcnt++;
         next_cycle();
      end
      check("midclr nodone", 64'(dcnt), 64'd0);
      run_op("after_clr", 3'b000, ra, 5'd9, 1'b0);

      for (int i = 0; i < 24; i++) begin
         run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 31)), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
